// File: rtl/pipe_cpu_hazard.sv
// pipe_cpu_hazard: 5-stage in-order core (IF/ID/EX/MEM/WB) for the 16-bit
// 4-bit-opcode ISA. It has a hazard interlock and predict-not-taken branches
// that resolve in MEM. External instruction and data memories read
// combinationally.
// Build option: define FORWARDING_EN to add EX operand forwarding. With
// forwarding, the interlock only covers load-use. Without it, the interlock
// covers every RAW hazard against ID/EX and EX/MEM.
module pipe_cpu_hazard #(
    parameter int XLEN = 16,
    parameter int NREG = 4,
    parameter int PC_W = 10,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic              dmem_we,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              stall
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_NOR  = 4'h4, OP_NAND = 4'h5, OP_SLT  = 4'h6, OP_ADDI = 4'h7,
        OP_LW   = 4'h8, OP_SW   = 4'h9, OP_BEQ  = 4'hA, OP_BNE  = 4'hB,
        OP_RSVC = 4'hC, OP_RSVD = 4'hD, OP_RSVE = 4'hE, OP_RSVF = 4'hF
    } opcode_t;

    logic [XLEN-1:0] regs [NREG];

    // Fetch / IF-ID
    logic [PC_W-1:0] pc;
    logic            if_id_valid;
    logic [15:0]     if_id_instr;
    logic [PC_W-1:0] if_id_pc;

    // ID-EX (dest is 0 for instructions that write no register)
    logic              id_ex_valid;
    opcode_t           id_ex_op;
    logic [REG_AW-1:0] id_ex_dest;
    logic [XLEN-1:0]   id_ex_a, id_ex_b;
    logic [7:0]        id_ex_imm8;
    logic [PC_W-1:0]   id_ex_pc;
`ifdef FORWARDING_EN
    logic [REG_AW-1:0] id_ex_rs, id_ex_rt;
`endif

    // EX-MEM
    logic              ex_mem_valid;
    opcode_t           ex_mem_op;
    logic [REG_AW-1:0] ex_mem_dest;
    logic [XLEN-1:0]   ex_mem_alu, ex_mem_sdata;
    logic              ex_mem_taken;
    logic [PC_W-1:0]   ex_mem_target;

    // MEM-WB
    logic              mem_wb_valid;
    logic [REG_AW-1:0] mem_wb_dest;
    logic [XLEN-1:0]   mem_wb_data;

    // ID decode
    opcode_t           id_op;
    logic              id_legal, id_rtype, id_use_rt;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd, id_dest;
    logic [XLEN-1:0]   id_rs_val, id_rt_val;
    logic              wb_write, hazard, flush;

    // EX datapath
    logic [XLEN-1:0]   ex_a, ex_b, ex_imm, ex_alu;
    logic              ex_taken;
    logic [PC_W-1:0]   ex_target;

    assign id_op     = opcode_t'(if_id_instr[15:12]);
    assign id_rs     = if_id_instr[10 +: REG_AW];
    assign id_rt     = if_id_instr[8 +: REG_AW];
    assign id_rd     = if_id_instr[6 +: REG_AW];
    assign id_legal  = if_id_valid && (if_id_instr[15:12] <= 4'hB);
    assign id_rtype  = (if_id_instr[15:12] <= 4'h6);
    assign id_use_rt = id_legal && (id_rtype || id_op == OP_SW || id_op == OP_BEQ || id_op == OP_BNE);
    assign id_dest   = id_rtype ? id_rd :
                       (id_op == OP_ADDI || id_op == OP_LW) ? id_rt : '0;

    assign wb_write  = mem_wb_valid && (mem_wb_dest != '0);
    assign flush     = ex_mem_valid && ex_mem_taken;

    function automatic logic src_hit(input logic [REG_AW-1:0] d,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic use_rs, input logic use_rt);
        return (d != '0) && ((use_rs && rs == d) || (use_rt && rt == d));
    endfunction

    // Register read with same-cycle writeback bypass; r0 always reads zero
    always_comb begin
        id_rs_val = regs[id_rs];
        id_rt_val = regs[id_rt];
        if (wb_write && mem_wb_dest == id_rs) id_rs_val = mem_wb_data;
        if (wb_write && mem_wb_dest == id_rt) id_rt_val = mem_wb_data;
        if (id_rs == '0) id_rs_val = '0;
        if (id_rt == '0) id_rt_val = '0;
    end

    // Interlock: decide whether the IF/ID instruction must wait
    always_comb begin
`ifdef FORWARDING_EN
        hazard = id_ex_valid && (id_ex_op == OP_LW) &&
                 src_hit(id_ex_dest, id_rs, id_rt, id_legal, id_use_rt);
`else
        hazard = (id_ex_valid && src_hit(id_ex_dest, id_rs, id_rt, id_legal, id_use_rt)) ||
                 (ex_mem_valid && src_hit(ex_mem_dest, id_rs, id_rt, id_legal, id_use_rt));
`endif
    end

    // A taken branch squashes everything younger, so it overrides the interlock
    assign stall = hazard && !flush;

    // EX operand selection
    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
`ifdef FORWARDING_EN
        if (ex_mem_valid && ex_mem_dest != '0 && ex_mem_op != OP_LW && ex_mem_dest == id_ex_rs)
            ex_a = ex_mem_alu;
        else if (wb_write && mem_wb_dest == id_ex_rs)
            ex_a = mem_wb_data;
        if (ex_mem_valid && ex_mem_dest != '0 && ex_mem_op != OP_LW && ex_mem_dest == id_ex_rt)
            ex_b = ex_mem_alu;
        else if (wb_write && mem_wb_dest == id_ex_rt)
            ex_b = mem_wb_data;
`endif
    end

    // ALU, branch compare and branch target
    always_comb begin
        ex_imm    = XLEN'($signed(id_ex_imm8));
        ex_target = id_ex_pc + PC_W'(1) + PC_W'($signed(id_ex_imm8));
        ex_taken  = 1'b0;
        ex_alu    = '0;
        case (id_ex_op)
            OP_ADD:  ex_alu = ex_a + ex_b;
            OP_SUB:  ex_alu = ex_a - ex_b;
            OP_AND:  ex_alu = ex_a & ex_b;
            OP_OR:   ex_alu = ex_a | ex_b;
            OP_NOR:  ex_alu = ~(ex_a | ex_b);
            OP_NAND: ex_alu = ~(ex_a & ex_b);
            OP_SLT:  ex_alu = XLEN'($signed(ex_a) < $signed(ex_b));
            OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + ex_imm;
            OP_BEQ:  ex_taken = (ex_a == ex_b);
            OP_BNE:  ex_taken = (ex_a != ex_b);
            default: ex_alu = '0;
        endcase
    end

    // PC and IF/ID: redirect on flush, hold on stall, otherwise advance
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else if (flush) begin
            pc          <= ex_mem_target;
            if_id_valid <= 1'b0;
        end else if (!hazard) begin
            pc          <= pc + PC_W'(1);
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc;
        end
    end

    // ID/EX: bubble on flush, stall or reserved opcode
    always_ff @(posedge clock) begin
        if (reset || flush || hazard || !id_legal) begin
            id_ex_valid <= 1'b0;
            id_ex_op    <= OP_ADD;
            id_ex_dest  <= '0;
        end else begin
            id_ex_valid <= 1'b1;
            id_ex_op    <= id_op;
            id_ex_dest  <= id_dest;
        end
        id_ex_a    <= id_rs_val;
        id_ex_b    <= id_rt_val;
        id_ex_imm8 <= if_id_instr[7:0];
        id_ex_pc   <= if_id_pc;
`ifdef FORWARDING_EN
        id_ex_rs   <= id_rs;
        id_ex_rt   <= id_rt;
`endif
    end

    // EX/MEM: the instruction behind a taken branch becomes a bubble
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            ex_mem_valid <= 1'b0;
            ex_mem_op    <= OP_ADD;
            ex_mem_dest  <= '0;
            ex_mem_taken <= 1'b0;
        end else begin
            ex_mem_valid <= id_ex_valid;
            ex_mem_op    <= id_ex_op;
            ex_mem_dest  <= id_ex_valid ? id_ex_dest : '0;
            ex_mem_taken <= id_ex_valid && ex_taken;
        end
        ex_mem_alu    <= ex_alu;
        ex_mem_sdata  <= ex_b;
        ex_mem_target <= ex_target;
    end

    // MEM/WB: pick load data or ALU result; non-writers retire with rd=0, data=0
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_wb_valid <= 1'b0;
            mem_wb_dest  <= '0;
            mem_wb_data  <= '0;
        end else begin
            mem_wb_valid <= ex_mem_valid;
            mem_wb_dest  <= ex_mem_valid ? ex_mem_dest : '0;
            if (ex_mem_valid && ex_mem_op == OP_LW)
                mem_wb_data <= dmem_rdata;
            else if (ex_mem_valid && (ex_mem_op == OP_ADDI || ex_mem_op <= OP_SLT))
                mem_wb_data <= ex_mem_alu;
            else
                mem_wb_data <= '0;
        end
    end

    // Register file write from WB; r0 is never written
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[mem_wb_dest] <= mem_wb_data;
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = ex_mem_alu;
    assign dmem_wdata = ex_mem_sdata;
    // Branches resolve in MEM, so no older instruction can still be flushing a store here
    assign dmem_we    = ex_mem_valid && (ex_mem_op == OP_SW);
    assign wb_valid   = mem_wb_valid;
    assign wb_rd      = mem_wb_dest;
    assign wb_data    = mem_wb_data;

endmodule

// File: tb/tb_pipe_cpu_hazard.sv
// Directed-program bench for pipe_cpu_hazard. Per-cycle outputs are captured
// into arrays, then checked against hand-computed retire cycles, values and
// memory contents. Expectations depend on whether FORWARDING_EN is defined.
module tb_pipe_cpu_hazard;

    localparam int XLEN = 16;
    localparam int NREG = 4;
    localparam int PC_W = 10;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            dmem_we;
    logic            wb_valid;
    logic [1:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall;

    always #5 clock = ~clock;

    pipe_cpu_hazard #(.XLEN(XLEN), .NREG(NREG), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall)
    );

    logic [15:0]     imem [1024];
    logic [XLEN-1:0] dmem [16];

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr[3:0]];
    always @(posedge clock) if (dmem_we) dmem[dmem_addr[3:0]] <= dmem_wdata;

    int checks = 0;
    int errors = 0;

    // captured per-cycle outputs; cycle 0 is the first cycle after reset release
    logic            v_at  [64];
    logic [1:0]      rd_at [64];
    logic [15:0]     d_at  [64];
    logic [PC_W-1:0] pc_at [64];
    logic            st_at [64];
    logic            we_at [64];
    int n_stall, n_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_prog(input logic [15:0] p [8]);
        for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) imem[i] = p[i];
    endtask

    // reset, then sample ncyc cycles; optionally pulse reset after sampling cycle rst_at
    task automatic run_prog(input int ncyc, input int rst_at);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n_stall = 0;
        n_we = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            v_at[k]  = wb_valid;
            rd_at[k] = wb_rd;
            d_at[k]  = wb_data;
            pc_at[k] = imem_addr;
            st_at[k] = stall;
            we_at[k] = dmem_we;
            if (stall) n_stall++;
            if (dmem_we) n_we++;
            if (k == rst_at) begin
                reset = 1'b1;
                @(posedge clock);
                #1 reset = 1'b0;
            end
        end
    endtask

    function automatic int find_rd(input int ncyc, input logic [1:0] rd);
        for (int k = 0; k < ncyc; k++) if (v_at[k] && rd_at[k] == rd) return k;
        return -1;
    endfunction

    function automatic int count_rd(input int ncyc, input logic [1:0] rd);
        int n = 0;
        for (int k = 0; k < ncyc; k++) if (v_at[k] && rd_at[k] == rd) n++;
        return n;
    endfunction

    logic [15:0] prog [8];
    int c, b;

    initial begin
        // 1: two loads feeding SLT (load-use)
        prog = '{16'h8100, 16'h8201, 16'h66C0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        load_prog(prog);
        dmem[0] = 16'd5; dmem[1] = 16'd7;
        run_prog(24, -1);
        check("rst_wb_valid", v_at[0], 0);
        check("rst_wb_rd", rd_at[0], 0);
        check("rst_wb_data", d_at[0], 0);
        check("rst_imem_addr", pc_at[0], 0);
        check("rst_stall", st_at[0], 0);
        check("rst_dmem_we", we_at[0], 0);
        c = find_rd(24, 2'd1);
        check("s1_lw1_cycle", c, 4);
        if (c >= 0) check("s1_lw1_data", d_at[c], 5);
        c = find_rd(24, 2'd2);
        check("s1_lw2_cycle", c, 5);
        if (c >= 0) check("s1_lw2_data", d_at[c], 7);
        c = find_rd(24, 2'd3);
        check("s1_slt_cycle", c, FWD ? 7 : 8);
        if (c >= 0) check("s1_slt_data", d_at[c], 1);
        check("s1_stalls", n_stall, FWD ? 1 : 2);

        // 2: ADDI -> ADD -> SUB dependency chain
        prog = '{16'h7103, 16'h0580, 16'h19C0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        load_prog(prog);
        run_prog(24, -1);
        c = find_rd(24, 2'd1);
        check("s2_addi_cycle", c, 4);
        if (c >= 0) check("s2_addi_data", d_at[c], 3);
        c = find_rd(24, 2'd2);
        check("s2_add_cycle", c, FWD ? 5 : 7);
        if (c >= 0) check("s2_add_data", d_at[c], 6);
        c = find_rd(24, 2'd3);
        check("s2_sub_cycle", c, FWD ? 6 : 10);
        if (c >= 0) check("s2_sub_data", d_at[c], 3);
        check("s2_stalls", n_stall, FWD ? 0 : 4);

        // 3a: unsorted pair -> BNE not taken, stores swap it
        prog = '{16'h8100, 16'h8201, 16'h66C0, 16'hBC02, 16'h9101, 16'h9200, 16'h0, 16'h0};
        load_prog(prog);
        dmem[0] = 16'd7; dmem[1] = 16'd5;
        run_prog(30, -1);
        c = find_rd(30, 2'd3);
        if (c >= 0) check("s3a_slt_data", d_at[c], 0);
        else check("s3a_slt_missing", c, 0);
        check("s3a_we_count", n_we, 2);
        check("s3a_m0", dmem[0], 5);
        check("s3a_m1", dmem[1], 7);

        // 3b: sorted pair -> BNE taken, three bubbles, no stores
        load_prog(prog);
        dmem[0] = 16'd5; dmem[1] = 16'd7;
        run_prog(30, -1);
        b = FWD ? 8 : 11;
        check("s3b_br_retire", v_at[b], 1);
        check("s3b_bubbles", {v_at[b+1], v_at[b+2], v_at[b+3]}, 0);
        check("s3b_target_retire", v_at[b+4], 1);
        check("s3b_we_count", n_we, 0);
        check("s3b_m0", dmem[0], 5);
        check("s3b_m1", dmem[1], 7);

        // 4: BNE self-loop, 4 cycles per iteration
        prog = '{16'h7104, 16'hB4FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        load_prog(prog);
        run_prog(24, -1);
        b = FWD ? 5 : 7;
        for (int j = 0; j < 12; j++)
            check($sformatf("s4_valid_%0d", j), v_at[b+j], (j % 4 == 0) ? 1 : 0);
        check("s4_pc_iter1", pc_at[b], 1);
        check("s4_pc_iter2", pc_at[b+4], 1);

        // 5: writes to r0 are discarded
        prog = '{16'h7009, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        load_prog(prog);
        run_prog(12, -1);
        check("s5_r0_valid", v_at[4], 1);
        check("s5_r0_rd", rd_at[4], 0);
        check("s5_add_rd", rd_at[5], 1);
        check("s5_add_data", d_at[5], 0);

        // 6: reset while a SW sits in ID/EX
        prog = '{16'h9002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        load_prog(prog);
        dmem[2] = 16'hAAAA;
        run_prog(10, 2);
        check("s6_we_after_rst", {we_at[3], we_at[4], we_at[5]}, 0);
        check("s6_pc_after_rst", pc_at[3], 0);
        check("s6_stall_after_rst", st_at[3], 0);
        check("s6_valid_after_rst", v_at[3], 0);
        check("s6_refetched_store", we_at[6], 1);

        // 7: BEQ taken skips one instruction
        prog = '{16'h7101, 16'hA001, 16'h7202, 16'h7303, 16'h0, 16'h0, 16'h0, 16'h0};
        load_prog(prog);
        run_prog(16, -1);
        check("s7_skipped", count_rd(16, 2'd2), 0);
        c = find_rd(16, 2'd3);
        check("s7_target_cycle", c, 9);
        if (c >= 0) check("s7_target_data", d_at[c], 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
